// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - Gowin PLLVR dynamic-divider sequencer
// Applies a divider preset, pulses PLL reset, qualifies lock and retries on timeout.
module pll_reconfig_ctrl #(
    parameter int                     NUM_MODES          = 2,
    parameter int                     MODE_W             = 1,
    parameter logic [6*NUM_MODES-1:0] MODE_IDIV          = {6'd3, 6'd3},
    parameter logic [6*NUM_MODES-1:0] MODE_FBDIV         = {6'd54, 6'd54},
    parameter logic [6*NUM_MODES-1:0] MODE_ODIV          = {6'd2, 6'd2},
    parameter int                     DEFAULT_MODE       = 0,
    parameter int                     RESET_CYCLES       = 16,
    parameter int                     LOCK_STABLE_CYCLES = 1024,
    parameter int                     LOCK_TIMEOUT       = 65536,
    parameter int                     MAX_RETRY          = 3,
    parameter int                     CNT_W              = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_sel,
    output logic              mode_ack,
    output logic              mode_nack,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic              locked,
    output logic              sys_rst,
    output logic              err,
    output logic [MODE_W-1:0] cur_mode,
    output logic [7:0]        relock_cnt
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    // Gowin dynamic select ports take the inverted divider value.
    localparam logic [5:0] ID_DEF = ~MODE_IDIV[6*DEFAULT_MODE +: 6];
    localparam logic [5:0] FB_DEF = ~MODE_FBDIV[6*DEFAULT_MODE +: 6];
    localparam logic [5:0] OD_DEF = ~MODE_ODIV[6*DEFAULT_MODE +: 6];

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        LOCKED,
        ERROR
    } state_t;

    state_t             state;
    logic               lock_m;
    logic               lock_s;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   stable_cnt;
    logic [RETRY_W-1:0] retry;
    logic               mode_valid;

    logic [5:0] id_chain [NUM_MODES+1];
    logic [5:0] fb_chain [NUM_MODES+1];
    logic [5:0] od_chain [NUM_MODES+1];

    assign id_chain[0] = '0;
    assign fb_chain[0] = '0;
    assign od_chain[0] = '0;

    // One-hot OR mux of the preset table keyed by the requested mode.
    for (genvar g = 0; g < NUM_MODES; g++) begin : g_tab
        logic hit;
        assign hit           = (mode_sel == MODE_W'(g));
        assign id_chain[g+1] = id_chain[g] | (hit ? ~MODE_IDIV[6*g +: 6]  : 6'd0);
        assign fb_chain[g+1] = fb_chain[g] | (hit ? ~MODE_FBDIV[6*g +: 6] : 6'd0);
        assign od_chain[g+1] = od_chain[g] | (hit ? ~MODE_ODIV[6*g +: 6]  : 6'd0);
    end

    assign mode_valid = (32'(mode_sel) < 32'(NUM_MODES));

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            stable_cnt <= '0;
            retry      <= '0;
            cur_mode   <= MODE_W'(DEFAULT_MODE);
            idsel      <= ID_DEF;
            fbdsel     <= FB_DEF;
            odsel      <= OD_DEF;
            pll_reset  <= 1'b1;
            locked     <= 1'b0;
            sys_rst    <= 1'b1;
            err        <= 1'b0;
            mode_ack   <= 1'b0;
            mode_nack  <= 1'b0;
            relock_cnt <= '0;
        end else begin
            mode_ack  <= 1'b0;
            mode_nack <= 1'b0;
            if (mode_req && mode_valid) begin
                cur_mode   <= mode_sel;
                idsel      <= id_chain[NUM_MODES];
                fbdsel     <= fb_chain[NUM_MODES];
                odsel      <= od_chain[NUM_MODES];
                mode_ack   <= 1'b1;
                retry      <= '0;
                err        <= 1'b0;
                cnt        <= '0;
                stable_cnt <= '0;
                state      <= RESET_PLL;
                pll_reset  <= 1'b1;
                locked     <= 1'b0;
                sys_rst    <= 1'b1;
            end else begin
                if (mode_req) begin
                    mode_nack <= 1'b1;
                end
                case (state)
                    RESET_PLL: begin
                        pll_reset <= 1'b1;
                        if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                            cnt        <= '0;
                            stable_cnt <= '0;
                            pll_reset  <= 1'b0;
                            state      <= WAIT_LOCK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        stable_cnt <= lock_s ? stable_cnt + 1'b1 : '0;
                        // Qualification is checked first so it wins a tie with timeout.
                        if (lock_s && stable_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            sys_rst <= 1'b0;
                            retry   <= '0;
                        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            cnt       <= '0;
                            retry     <= retry + 1'b1;
                            pll_reset <= 1'b1;
                            if (32'(retry) + 32'd1 < 32'(MAX_RETRY)) begin
                                state <= RESET_PLL;
                            end else begin
                                state <= ERROR;
                                err   <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!lock_s) begin
                            state     <= RESET_PLL;
                            cnt       <= '0;
                            retry     <= '0;
                            pll_reset <= 1'b1;
                            locked    <= 1'b0;
                            sys_rst   <= 1'b1;
                            if (relock_cnt != 8'hFF) begin
                                relock_cnt <= relock_cnt + 8'd1;
                            end
                        end
                    end
                    ERROR: begin
                        pll_reset <= 1'b1;
                        err       <= 1'b1;
                        locked    <= 1'b0;
                        sys_rst   <= 1'b1;
                    end
                    default: state <= RESET_PLL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;

    logic       clk;
    logic       reset;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic       mode_nack;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
    logic       locked;
    logic       sys_rst;
    logic       err;
    logic [1:0] cur_mode;
    logic [7:0] relock_cnt;

    int total = 0;
    int bad   = 0;

    pll_reconfig_ctrl #(
        .NUM_MODES(2),
        .MODE_W(2),
        .MODE_IDIV({6'd1, 6'd3}),
        .MODE_FBDIV({6'd54, 6'd54}),
        .MODE_ODIV({6'd2, 6'd2}),
        .DEFAULT_MODE(0),
        .RESET_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT(32),
        .MAX_RETRY(2),
        .CNT_W(17)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode_req(mode_req),
        .mode_sel(mode_sel),
        .mode_ack(mode_ack),
        .mode_nack(mode_nack),
        .pll_lock(pll_lock),
        .pll_reset(pll_reset),
        .idsel(idsel),
        .fbdsel(fbdsel),
        .odsel(odsel),
        .locked(locked),
        .sys_rst(sys_rst),
        .err(err),
        .cur_mode(cur_mode),
        .relock_cnt(relock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (pll_reset === lvl && n < 1000) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
    endtask

    task automatic request(input logic [1:0] sel);
        mode_sel = sel;
        mode_req = 1'b1;
        step(1);
        mode_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; mode_req = 1'b0; mode_sel = 2'd0; pll_lock = 1'b0;
        step(3);
        total++; if (pll_reset !== 1'b1) begin bad++; $display("FAIL rst_pll_reset got=%b want=1", pll_reset); end
        total++; if (locked !== 1'b0 || sys_rst !== 1'b1) begin bad++; $display("FAIL rst_locked got=%b/%b want=0/1", locked, sys_rst); end
        total++; if (err !== 1'b0 || mode_ack !== 1'b0 || mode_nack !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b want=000", err, mode_ack, mode_nack); end
        total++; if (relock_cnt !== 8'd0 || cur_mode !== 2'd0) begin bad++; $display("FAIL rst_cnt_mode got=%0d/%0d want=0/0", relock_cnt, cur_mode); end
        total++; if (idsel !== 6'h3C || fbdsel !== 6'h09 || odsel !== 6'h3D) begin bad++; $display("FAIL rst_selects got=%h/%h/%h want=3c/09/3d", idsel, fbdsel, odsel); end
    endtask

    task automatic test_power_up;
        int n;
        reset = 1'b0;
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL pwrup_reset_len got=%0d want=4", n); end
        pll_lock = 1'b1;
        wait_locked(n);
        total++; if (n !== 10) begin bad++; $display("FAIL pwrup_lock_latency got=%0d want=10", n); end
        total++; if (sys_rst !== 1'b0 || idsel !== 6'h3C) begin bad++; $display("FAIL pwrup_outputs got=%b/%h want=0/3c", sys_rst, idsel); end
    endtask

    task automatic test_glitch;
        int n;
        pll_lock = 1'b0;
        request(2'd0);
        total++; if (mode_ack !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL glitch_ack got=%b/%b want=1/0", mode_ack, locked); end
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL glitch_reset_len got=%0d want=4", n); end
        pll_lock = 1'b1; step(5);
        pll_lock = 1'b0; step(2);
        pll_lock = 1'b1;
        wait_locked(n);
        total++; if (n !== 10) begin bad++; $display("FAIL glitch_lock_latency got=%0d want=10", n); end
        total++; if (err !== 1'b0 || pll_reset !== 1'b0) begin bad++; $display("FAIL glitch_no_retry got=%b/%b want=0/0", err, pll_reset); end
    endtask

    task automatic test_no_lock;
        int n;
        pll_lock = 1'b0;
        request(2'd0);
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL nolock_pulse1 got=%0d want=4", n); end
        count_level(1'b0, n);
        total++; if (n !== 32) begin bad++; $display("FAIL nolock_window1 got=%0d want=32", n); end
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL nolock_pulse2 got=%0d want=4", n); end
        count_level(1'b0, n);
        total++; if (n !== 32) begin bad++; $display("FAIL nolock_window2 got=%0d want=32", n); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nolock_err got=%b want=1", err); end
        step(10);
        total++; if (err !== 1'b1 || pll_reset !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL nolock_hold got=%b/%b/%b want=1/1/0", err, pll_reset, locked); end
        request(2'd0);
        total++; if (mode_ack !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL nolock_recover got=%b/%b want=1/0", mode_ack, err); end
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL nolock_recover_pulse got=%0d want=4", n); end
    endtask

    task automatic test_lock_loss;
        int n;
        int stuck;
        stuck = 0;
        pll_lock = 1'b1;
        wait_locked(n);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_initial_lock got=%b want=1", locked); end
        pll_lock = 1'b0; step(1);
        pll_lock = 1'b1; step(1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_early_drop got=%b want=1", locked); end
        step(1);
        total++; if (locked !== 1'b0 || sys_rst !== 1'b1 || pll_reset !== 1'b1) begin bad++; $display("FAIL loss_drop got=%b/%b/%b want=0/1/1", locked, sys_rst, pll_reset); end
        total++; if (relock_cnt !== 8'd1) begin bad++; $display("FAIL loss_count1 got=%0d want=1", relock_cnt); end
        wait_locked(n);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_relock got=%b want=1", locked); end
        for (int i = 0; i < 255; i++) begin
            pll_lock = 1'b0; step(1);
            pll_lock = 1'b1;
            n = 0;
            while (locked === 1'b1 && n < 20) begin step(1); n++; end
            if (n >= 20) stuck++;
            wait_locked(n);
            if (n >= 1000) stuck++;
            if (i == 253) begin
                total++; if (relock_cnt !== 8'd255) begin bad++; $display("FAIL loss_count255 got=%0d want=255", relock_cnt); end
            end
        end
        total++; if (relock_cnt !== 8'd255) begin bad++; $display("FAIL loss_saturate got=%0d want=255", relock_cnt); end
        total++; if (stuck !== 0) begin bad++; $display("FAIL loss_loop_timeouts got=%0d want=0", stuck); end
    endtask

    task automatic test_mode_switch;
        int n;
        request(2'd1);
        total++; if (mode_ack !== 1'b1 || cur_mode !== 2'd1 || idsel !== 6'h3E) begin bad++; $display("FAIL switch_apply got=%b/%0d/%h want=1/1/3e", mode_ack, cur_mode, idsel); end
        total++; if (pll_reset !== 1'b1 || locked !== 1'b0 || sys_rst !== 1'b1) begin bad++; $display("FAIL switch_reset got=%b/%b/%b want=1/0/1", pll_reset, locked, sys_rst); end
        step(1);
        total++; if (mode_ack !== 1'b0) begin bad++; $display("FAIL switch_ack_pulse got=%b want=0", mode_ack); end
        wait_locked(n);
        total++; if (locked !== 1'b1 || fbdsel !== 6'h09) begin bad++; $display("FAIL switch_relock got=%b/%h want=1/09", locked, fbdsel); end
        request(2'd2);
        total++; if (mode_nack !== 1'b1 || mode_ack !== 1'b0) begin bad++; $display("FAIL nack_pulse got=%b/%b want=1/0", mode_nack, mode_ack); end
        total++; if (cur_mode !== 2'd1 || idsel !== 6'h3E || locked !== 1'b1) begin bad++; $display("FAIL nack_no_effect got=%0d/%h/%b want=1/3e/1", cur_mode, idsel, locked); end
        step(1);
        total++; if (mode_nack !== 1'b0 || locked !== 1'b1 || pll_reset !== 1'b0) begin bad++; $display("FAIL nack_after got=%b/%b/%b want=0/1/0", mode_nack, locked, pll_reset); end
    endtask

    task automatic test_reset_mid;
        int n;
        request(2'd1);
        pll_lock = 1'b0;
        count_level(1'b1, n);
        step(20);
        total++; if (pll_reset !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_in_wait got=%b/%b want=0/0", pll_reset, err); end
        reset = 1'b1;
        step(1);
        total++; if (pll_reset !== 1'b1 || locked !== 1'b0 || sys_rst !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL mid_reset_ctrl got=%b%b%b%b want=1010", pll_reset, locked, sys_rst, err); end
        total++; if (cur_mode !== 2'd0 || idsel !== 6'h3C || relock_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_mode got=%0d/%h/%0d want=0/3c/0", cur_mode, idsel, relock_cnt); end
        reset = 1'b0;
        count_level(1'b1, n);
        total++; if (n !== 4) begin bad++; $display("FAIL mid_reset_pulse got=%0d want=4", n); end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_glitch;
        test_no_lock;
        test_lock_loss;
        test_mode_switch;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer for a Gowin PLLVR used in dynamic-divider mode (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true").
- Holds a parametrised table of NUM_MODES divider presets (e.g. 720p/480p pixel/serial clocks). Drives IDSEL/FBDSEL/ODSEL, sequences PLL reset, qualifies lock and retries on timeout.
- Produces a downstream reset for the TMDS/DVI clock domains.
- Runs on the free-running 27 MHz crystal clock that also feeds PLL CLKIN.

Parameters:
NUM_MODES, 2, number of divider presets
MODE_W, 1, width of mode_sel (ceil log2 NUM_MODES, min 1)
MODE_IDIV, {6'd3,6'd3}, packed 6-bit IDIV_SEL per mode; mode i at bits [6i+5:6i]
MODE_FBDIV, {6'd54,6'd54}, packed 6-bit FBDIV_SEL per mode
MODE_ODIV, {6'd2,6'd2}, packed 6-bit ODIV_SEL per mode
DEFAULT_MODE, 0, mode loaded at reset
RESET_CYCLES, 16, pll_reset pulse length in clk cycles (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK per attempt
MAX_RETRY, 3, attempts before ERROR (>=1)
CNT_W, 17, width of shared cycle counter; must hold every count parameter

Ports:
clk  in  1  free-running 27 MHz reference
reset  in  1  synchronous, active-high
mode_req  in  1  single-cycle request to switch mode
mode_sel  in  MODE_W  requested mode, valid with mode_req
mode_ack  out  1  one-cycle pulse: request accepted
mode_nack  out  1  one-cycle pulse: mode_sel >= NUM_MODES, ignored
pll_lock  in  1  PLLVR LOCK, asynchronous
pll_reset  out  1  to PLLVR RESET
idsel  out  6  to PLLVR IDSEL
fbdsel  out  6  to PLLVR FBDSEL
odsel  out  6  to PLLVR ODSEL
locked  out  1  lock qualified and stable
sys_rst  out  1  downstream reset, = ~locked
err  out  1  retries exhausted
cur_mode  out  MODE_W  mode currently applied
relock_cnt  out  8  lock-loss events, saturates at 255

Behaviour:
- Reset values: state=RESET_PLL, counter=0, retry=0, cur_mode=DEFAULT_MODE, pll_reset=1, locked=0, sys_rst=1, err=0, mode_ack=0, mode_nack=0, relock_cnt=0.
- Select encoding: idsel/fbdsel/odsel = bitwise inverse of the table entry for cur_mode (Gowin dynamic-port encoding). Registered; they update in the same cycle cur_mode changes.
- pll_lock passes through a 2-flop synchroniser to lock_s. Only lock_s is used.
- All outputs are registered.
- RESET_PLL: pll_reset=1. Counter runs 0..RESET_CYCLES-1, then go to WAIT_LOCK with counter=0. pll_reset is high for exactly RESET_CYCLES cycles.
- WAIT_LOCK: pll_reset=0.
  - Stable count increments while lock_s=1 and clears to 0 when lock_s=0.
  - When the stable count reaches LOCK_STABLE_CYCLES-1 with lock_s=1, go to LOCKED and clear retry.
  - A separate timeout count increments every cycle. On reaching LOCK_TIMEOUT-1, retry increments. If retry+1 < MAX_RETRY, go to RESET_PLL; otherwise go to ERROR.
  - If lock qualification and timeout hit in the same cycle, lock qualification wins.
- LOCKED: locked=1, sys_rst=0. If lock_s=0 for any single cycle: go to RESET_PLL, locked=0 and sys_rst=1 on the next edge, relock_cnt+1 (saturating), retry=0.
- ERROR: pll_reset=1, err=1, locked=0. Exits only via an accepted mode_req or reset.
- mode_req handling (accepted in any state):
  - If mode_sel < NUM_MODES: cur_mode=mode_sel, selects updated, mode_ack pulse, retry=0, err=0, counters cleared, go to RESET_PLL. locked drops to 0 on the same edge.
  - If the requested mode equals cur_mode, the full re-sequence still runs.
  - If mode_sel >= NUM_MODES: mode_nack pulse, no other effect.
- Priority within one cycle: reset > valid mode_req > lock loss / timeout / qualification.
- reset asserted mid-operation returns to reset values on the next edge, regardless of state.

Test Plan:
Use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRY=2, NUM_MODES=2, MODE_IDIV={6'd1,6'd3}.
1. Power-up lock: release reset; pll_lock rises the cycle pll_reset falls -> pll_reset high exactly 4 cycles; locked=1, sys_rst=0 exactly 10 cycles after pll_lock rises; idsel=6'h3C.
2. Lock glitch: in WAIT_LOCK, pll_lock high 5 cycles, low 2, then high -> locked asserts 10 cycles after the final rise; no retry, err=0.
3. No lock: hold pll_lock=0 -> two 32-cycle WAIT_LOCK windows separated by one 4-cycle pll_reset pulse; then err=1 and pll_reset=1 held. Then mode_req with mode_sel=0 -> mode_ack, err=0, new 4-cycle reset pulse.
4. Lock loss: in LOCKED drop pll_lock 1 cycle -> locked=0 and sys_rst=1 three cycles later (sync + state); relock_cnt=1; re-lock sequence completes. 256 losses -> relock_cnt stays 255.
5. Mode switch: in LOCKED, mode_req with mode_sel=1 -> mode_ack pulse, cur_mode=1, idsel=6'h3E, pll_reset=1 and locked=0 on the same edge. mode_sel=2 with MODE_W=2 build -> mode_nack only, state unchanged.
6. Reset mid-sequence: assert reset during WAIT_LOCK cycle 20 -> all outputs at reset values next edge; cur_mode=DEFAULT_MODE.
